// File: rtl/pwm_pkg.sv
// Shared constants and FSM state type for the pwm block family.
package pwm_pkg;

  localparam int unsigned DEF_DUTY_W = 4;
  localparam int unsigned DEF_STEP_W = 4;
  localparam int unsigned FRAME_LAST = (1 << DEF_DUTY_W) - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_DONE = 2'd2
  } ramp_state_e;

  // Last count value of a frame for a counter of width w.
  function automatic int unsigned frame_last(input int unsigned w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/pwm_frame_cnt.sv
// Free-running frame counter; frame_end_out is high on the last cycle of each frame.
module pwm_frame_cnt
  import pwm_pkg::*;
#(
  parameter int unsigned W = DEF_DUTY_W
) (
  input  logic clk_in,
  input  logic rst_n_in,
  output logic frame_end_out
);

  localparam logic [W-1:0] PRE_LAST = W'(frame_last(W) - 1);

  logic [W-1:0] count;

  // frame_end is registered one count early so it lines up with count == last.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count         <= '0;
      frame_end_out <= 1'b0;
    end else begin
      count         <= count + W'(1);
      frame_end_out <= (count == PRE_LAST);
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Steps the pwm duty one LSB per N frames toward a target, changing only at frame boundaries.
// Optional abort input is enabled with `define PWM_RAMP_ABORT_EN.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned DUTY_W = DEF_DUTY_W,
  parameter int unsigned STEP_W = DEF_STEP_W
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              start_in,
  input  logic [DUTY_W-1:0] target_in,
  input  logic [STEP_W-1:0] step_frames_in,
`ifdef PWM_RAMP_ABORT_EN
  input  logic              abort_in,
`endif
  output logic              start_ready_out,
  output logic [DUTY_W-1:0] duty_out,
  output logic              frame_end_out,
  output logic              busy_out,
  output logic              done_out
);

  localparam int unsigned SC_W = STEP_W + 1;

  ramp_state_e       state_q, state_d;
  logic [DUTY_W-1:0] duty_d, target_q, target_d, duty_step;
  logic [STEP_W-1:0] step_q, step_d, step_cnt_q, step_cnt_d;
  logic [SC_W-1:0]   step_eff, step_cnt_inc;

  pwm_frame_cnt #(.W(DUTY_W)) u_frame_cnt (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .frame_end_out(frame_end_out)
  );

  // Next-state and datapath; a step of 0 behaves as 1.
  always_comb begin
    state_d      = state_q;
    duty_d       = duty_out;
    target_d     = target_q;
    step_d       = step_q;
    step_cnt_d   = step_cnt_q;
    step_eff     = (step_q == '0) ? SC_W'(1) : {1'b0, step_q};
    step_cnt_inc = {1'b0, step_cnt_q} + SC_W'(1);
    duty_step    = (target_q > duty_out) ? duty_out + DUTY_W'(1) : duty_out - DUTY_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          target_d   = target_in;
          step_d     = step_frames_in;
          step_cnt_d = '0;
          state_d    = (target_in == duty_out) ? ST_DONE : ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (frame_end_out) begin
          if (step_cnt_inc >= step_eff) begin
            duty_d     = duty_step;
            step_cnt_d = '0;
            if (duty_step == target_q) state_d = ST_DONE;
          end else begin
            step_cnt_d = step_cnt_inc[STEP_W-1:0];
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

`ifdef PWM_RAMP_ABORT_EN
    // Abort wins over a step update landing on the same edge.
    if ((state_q == ST_RAMP) && abort_in) begin
      duty_d     = '0;
      step_cnt_d = '0;
      state_d    = ST_IDLE;
    end
`endif
  end

  // State, datapath and registered status outputs derived from the next state.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q         <= ST_IDLE;
      duty_out        <= '0;
      target_q        <= '0;
      step_q          <= '0;
      step_cnt_q      <= '0;
      start_ready_out <= 1'b1;
      busy_out        <= 1'b0;
      done_out        <= 1'b0;
    end else begin
      state_q         <= state_d;
      duty_out        <= duty_d;
      target_q        <= target_d;
      step_q          <= step_d;
      step_cnt_q      <= step_cnt_d;
      start_ready_out <= (state_d == ST_IDLE);
      busy_out        <= (state_d != ST_IDLE);
      done_out        <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: random ramps against a frame-arithmetic reference model.
module tb_pwm_ramp_ctrl;

  localparam int unsigned DUTY_W = 4;
  localparam int unsigned STEP_W = 4;
  localparam int          FRAME  = 1 << DUTY_W;

  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic              start_in;
  logic [DUTY_W-1:0] target_in;
  logic [STEP_W-1:0] step_frames_in;
  logic              start_ready_out;
  logic [DUTY_W-1:0] duty_out;
  logic              frame_end_out;
  logic              busy_out;
  logic              done_out;
`ifdef PWM_RAMP_ABORT_EN
  logic              abort_in;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: edges since reset release plus the parameters of the active ramp.
  int e;
  bit m_act;
  int m_k, m_d0, m_t, m_s, m_base;
  bit abort_pend;
  int md;
  bit mb, mdn;

  pwm_ramp_ctrl #(.DUTY_W(DUTY_W), .STEP_W(STEP_W)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .start_in       (start_in),
    .target_in      (target_in),
    .step_frames_in (step_frames_in),
`ifdef PWM_RAMP_ABORT_EN
    .abort_in       (abort_in),
`endif
    .start_ready_out(start_ready_out),
    .duty_out       (duty_out),
    .frame_end_out  (frame_end_out),
    .busy_out       (busy_out),
    .done_out       (done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, e);
    end
  endtask

  // Duty after edge ee: one step per s frame boundaries after the accept edge, capped at the target.
  function automatic void model(input int ee, output int duty, output bit busy, output bit done);
    int n, endp, b, st;
    if (!m_act) begin
      duty = m_base; busy = 1'b0; done = 1'b0;
      return;
    end
    n    = (m_t > m_d0) ? m_t - m_d0 : m_d0 - m_t;
    endp = (n == 0) ? m_k : (m_k / FRAME + m_s * n) * FRAME;
    b    = ee / FRAME - m_k / FRAME;
    st   = b / m_s;
    if (st > n) st = n;
    duty = (m_t >= m_d0) ? m_d0 + st : m_d0 - st;
    busy = (ee <= endp);
    done = (ee == endp);
  endfunction

  task automatic check_outputs();
    int d;
    bit b, dn;
    model(e, d, b, dn);
    check_eq("duty", int'(duty_out), d);
    check_eq("busy", int'(busy_out), int'(b));
    check_eq("ready", int'(start_ready_out), int'(!b));
    check_eq("done", int'(done_out), int'(dn));
    check_eq("frame_end", int'(frame_end_out), int'((e % FRAME) == FRAME - 1));
  endtask

  task automatic tick();
    int d;
    bit b, dn;
    @(posedge clk_in);
    #1;
    e++;
    if (abort_pend) begin m_act = 1'b0; m_base = 0; abort_pend = 1'b0; end
    model(e, d, b, dn);
    if (m_act && !b) begin m_act = 1'b0; m_base = m_t; end
    check_outputs();
  endtask

  // One-cycle start pulse; the model accepts it only when it expects the block idle.
  task automatic request(input int t, input int s);
    if (!m_act) begin
      m_act = 1'b1; m_k = e + 1; m_d0 = m_base; m_t = t; m_s = (s == 0) ? 1 : s;
    end
    start_in       = 1'b1;
    target_in      = DUTY_W'(t);
    step_frames_in = STEP_W'(s);
    tick();
    start_in = 1'b0;
  endtask

  task automatic run_ramp(input int t, input int s, input int inject_at, input bit junk);
    int d;
    bit b, dn;
    bit injected;
    injected = 1'b0;
    request(t, s);
    for (int i = 0; i < 4000 && m_act; i++) begin
      model(e, d, b, dn);
      if (!injected && inject_at >= 0 && d == inject_at) begin
        injected = 1'b1;
        request(15, 7);
      end else if (junk && $urandom_range(7) == 0) begin
        request(int'($urandom_range(15)), int'($urandom_range(15)));
      end else begin
        tick();
      end
    end
    check_eq("ramp_timeout", int'(m_act), 0);
  endtask

  task automatic run_to_duty(input int v);
    for (int i = 0; i < 2000; i++) begin
      model(e, md, mb, mdn);
      if (md == v) break;
      tick();
    end
    model(e, md, mb, mdn);
    check_eq("reach_duty", md, v);
  endtask

  initial begin
    rst_n_in = 1'b0; start_in = 1'b0; target_in = '0; step_frames_in = '0;
`ifdef PWM_RAMP_ABORT_EN
    abort_in = 1'b0;
`endif
    e = 0; m_act = 1'b0; m_base = 0; abort_pend = 1'b0;
    m_k = 0; m_d0 = 0; m_t = 0; m_s = 1;

    repeat (3) @(posedge clk_in);
    #1;
    check_eq("rst_duty", int'(duty_out), 0);
    check_eq("rst_ready", int'(start_ready_out), 1);
    check_eq("rst_busy", int'(busy_out), 0);
    check_eq("rst_done", int'(done_out), 0);
    check_eq("rst_frame_end", int'(frame_end_out), 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    e = 0;
    check_outputs();

    // Directed ramps: up, down with step 2, equal target, step 0, ignored mid-ramp start.
    run_ramp(10, 1, -1, 1'b0);
    run_ramp(3, 2, -1, 1'b0);
    run_ramp(3, 5, -1, 1'b0);
    run_ramp(0, 0, -1, 1'b0);
    run_ramp(10, 1, 4, 1'b0);

    // Random ramps with idle gaps and stray starts while busy.
    for (int r = 0; r < 16; r++) begin
      repeat ($urandom_range(4)) tick();
      run_ramp(int'($urandom_range(15)), int'($urandom_range(2)), -1, 1'b1);
    end

    // Asynchronous reset in the middle of a ramp.
    run_ramp(0, 1, -1, 1'b0);
    request(10, 1);
    run_to_duty(5);
    #2;
    rst_n_in = 1'b0;
    #1;
    check_eq("midrst_duty", int'(duty_out), 0);
    check_eq("midrst_ready", int'(start_ready_out), 1);
    check_eq("midrst_busy", int'(busy_out), 0);
    check_eq("midrst_done", int'(done_out), 0);
    m_act = 1'b0; m_base = 0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    e = 0;
    check_outputs();
    run_ramp(2, 1, -1, 1'b0);

`ifdef PWM_RAMP_ABORT_EN
    // Abort mid-ramp drops duty to 0 on the next edge without a completion pulse.
    run_ramp(0, 1, -1, 1'b0);
    request(10, 1);
    run_to_duty(5);
    abort_in = 1'b1;
    abort_pend = 1'b1;
    tick();
    abort_in = 1'b0;
    repeat (FRAME * 2) tick();
    run_ramp(1, 1, -1, 1'b0);
`endif

    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

endmodule
